// File: rtl/cpu_defs.sv
// Shared definitions for the instruction-memory loader: geometry, NOP encoding
// and the loader state encoding.
package cpu_defs;

  localparam int IMEM_WIDTH    = 32;
  localparam int IMEM_ADDRSIZE = 12;

  localparam logic [31:0] NOP_INSN = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_LEN_HI = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_DATA   = 3'd2,
    ST_CSUM   = 3'd3,
    ST_RUN    = 3'd4,
    ST_ERR    = 3'd5
  } loader_state_t;

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one synchronous write port, one asynchronous read port.
// Contents are never reset, so earlier loads survive reset and aborted frames.
module imem_array #(
  parameter int WIDTH    = 32,
  parameter int ADDRSIZE = 12
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDRSIZE-1:0] waddr,
  input  logic [WIDTH-1:0]    wdata,
  input  logic [ADDRSIZE-1:0] raddr,
  output logic [WIDTH-1:0]    rdata
);

  logic [WIDTH-1:0] mem [1<<ADDRSIZE];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/prog_loader_imem.sv
// Byte-serial program loader in front of the instruction memory: parses the
// framed stream, packs big-endian words, verifies the XOR checksum, gates core reset.
module prog_loader_imem
  import cpu_defs::*;
#(
  parameter int WIDTH    = cpu_defs::IMEM_WIDTH,
  parameter int ADDRSIZE = cpu_defs::IMEM_ADDRSIZE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          byte_in,
  input  logic                byte_valid,
  output logic                byte_ready,
  input  logic                load_req,
  input  logic [ADDRSIZE-1:0] INS_ADDR,
  output logic [0:WIDTH-1]    INS_MEM,
  output logic                cpu_rst,
  output logic                load_done,
  output logic                load_err,
  output logic [ADDRSIZE-1:0] word_count
);

  loader_state_t state, next_state;

  logic                accept;
  logic                we;
  logic [3:0]          len_hi_nib;
  logic [ADDRSIZE-1:0] n_from_lo;
  logic [ADDRSIZE-1:0] n_words;
  logic [ADDRSIZE-1:0] wr_ptr;
  logic [1:0]          byte_cnt;
  logic [23:0]         pack;
  logic [7:0]          xor_acc;
  logic                err_flag;
  logic [WIDTH-1:0]    wdata;
  logic [WIDTH-1:0]    rdata;

  assign byte_ready = (state == ST_LEN_HI) || (state == ST_LEN_LO) ||
                      (state == ST_DATA)   || (state == ST_CSUM);
  assign accept     = byte_valid && byte_ready;
  assign n_from_lo  = ADDRSIZE'({len_hi_nib, byte_in});
  assign we         = accept && (state == ST_DATA) && (byte_cnt == 2'd3);
  assign wdata      = WIDTH'({pack, byte_in});

  assign load_done  = (state == ST_RUN);
  assign load_err   = (state == ST_ERR);
  assign word_count = wr_ptr;
  assign INS_MEM    = (state == ST_RUN) ? rdata : WIDTH'(NOP_INSN);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_LEN_HI;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_LEN_HI: if (accept) next_state = ST_LEN_LO;
      ST_LEN_LO: if (accept) next_state = (n_from_lo == '0) ? ST_CSUM : ST_DATA;
      ST_DATA:   if (we && ((wr_ptr + ADDRSIZE'(1)) == n_words)) next_state = ST_CSUM;
      ST_CSUM:   if (accept) next_state = ((byte_in == xor_acc) && !err_flag) ? ST_RUN : ST_ERR;
      ST_RUN,
      ST_ERR:    if (load_req) next_state = ST_LEN_HI;
      default:   next_state = ST_LEN_HI;
    endcase
  end

  // Frame datapath; cpu_rst follows the next state so it changes on the RUN entry/exit edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_hi_nib <= '0;
      n_words    <= '0;
      wr_ptr     <= '0;
      byte_cnt   <= '0;
      pack       <= '0;
      xor_acc    <= '0;
      err_flag   <= 1'b0;
      cpu_rst    <= 1'b1;
    end else begin
      cpu_rst <= (next_state != ST_RUN);
      if (accept) xor_acc <= xor_acc ^ byte_in;
      case (state)
        ST_LEN_HI: if (accept) begin
          len_hi_nib <= byte_in[3:0];
          err_flag   <= |byte_in[7:4];
        end
        ST_LEN_LO: if (accept) n_words <= n_from_lo;
        ST_DATA: if (accept) begin
          byte_cnt <= byte_cnt + 2'd1;
          pack     <= {pack[15:0], byte_in};
          if (byte_cnt == 2'd3) wr_ptr <= wr_ptr + ADDRSIZE'(1);
        end
        ST_RUN,
        ST_ERR: if (load_req) begin
          wr_ptr   <= '0;
          byte_cnt <= '0;
          xor_acc  <= '0;
          err_flag <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  imem_array #(.WIDTH(WIDTH), .ADDRSIZE(ADDRSIZE)) u_array (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (INS_ADDR),
    .rdata (rdata)
  );

endmodule
